// File: rtl/wb_byte_bridge.sv
// Byte-stream host link to 8-bit wishbone master bridge.
// Host bytes set a 24-bit address and run counted read/write bursts on the bus.
module wb_byte_bridge #(
  parameter int unsigned timeout_cycles = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:7]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [0:7]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [0:23] wb_adr_o,
  output logic [0:7]  wb_dat_o,
  input  logic [0:7]  wb_dat_i,
  output logic        wb_we_o,
  output logic [0:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  output logic        timeout
);

  typedef enum logic [3:0] {
    IDLE, ADDR0, ADDR1, ADDR2, COUNT, WDATA, WBUS, RBUS, RSEND
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(timeout_cycles - 1);

  state_t      state, state_nxt;
  logic [0:23] addr;
  logic [8:0]  cnt;
  logic [15:0] tmo_cnt;
  logic        dir_wr;
  logic        gap;
  logic        rx_fire, tx_fire, on_bus, done, tmo_hit, last;

  assign on_bus  = (state == WBUS) || (state == RBUS);
  assign rx_fire = rx_valid && rx_ready;
  assign tx_fire = tx_valid && tx_ready;
  // An ack on the final allowed cycle wins over the timeout.
  assign tmo_hit = on_bus && !wb_ack_i && (tmo_cnt == TMO_LAST);
  assign done    = on_bus && (wb_ack_i || tmo_hit);
  assign last    = (cnt == 9'd1);

  assign wb_adr_o = addr;
  assign wb_sel_o = 1'b1;
  assign wb_cyc_o = on_bus;
  assign wb_stb_o = on_bus;
  assign wb_we_o  = (state == WBUS);
  assign tx_valid = (state == RSEND);

  // gap holds off the next data byte for one cycle after a write access,
  // so the bus always sees an idle cycle and writes run at a 3-cycle cadence.
  assign rx_ready = !reset &&
                    ((state inside {IDLE, ADDR0, ADDR1, ADDR2, COUNT}) ||
                     ((state == WDATA) && !gap));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (rx_fire) begin
          case (rx_data)
            8'h01:        state_nxt = ADDR0;
            8'h02, 8'h03: state_nxt = COUNT;
            default:      state_nxt = IDLE;
          endcase
        end
      end
      ADDR0: if (rx_fire) state_nxt = ADDR1;
      ADDR1: if (rx_fire) state_nxt = ADDR2;
      ADDR2: if (rx_fire) state_nxt = IDLE;
      COUNT: if (rx_fire) state_nxt = dir_wr ? WDATA : RBUS;
      WDATA: if (rx_fire) state_nxt = WBUS;
      WBUS:  if (done)    state_nxt = last ? IDLE : WDATA;
      RBUS:  if (done)    state_nxt = RSEND;
      RSEND: if (tx_fire) state_nxt = last ? IDLE : RBUS;
      default:            state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      cnt      <= '0;
      tmo_cnt  <= '0;
      dir_wr   <= 1'b0;
      gap      <= 1'b0;
      wb_dat_o <= '0;
      tx_data  <= '0;
      timeout  <= 1'b0;
    end else begin
      state   <= state_nxt;
      timeout <= tmo_hit;
      gap     <= 1'b0;
      tmo_cnt <= (on_bus && !done) ? tmo_cnt + 16'd1 : 16'd0;
      unique case (state)
        IDLE:  if (rx_fire && (rx_data == 8'h02 || rx_data == 8'h03))
                 dir_wr <= (rx_data == 8'h02);
        ADDR0: if (rx_fire) addr[0:7]   <= rx_data;
        ADDR1: if (rx_fire) addr[8:15]  <= rx_data;
        ADDR2: if (rx_fire) addr[16:23] <= rx_data;
        COUNT: if (rx_fire) cnt <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
        WDATA: if (rx_fire) wb_dat_o <= rx_data;
        WBUS: begin
          if (done) begin
            addr <= addr + 24'd1;
            cnt  <= cnt - 9'd1;
            gap  <= 1'b1;
          end
        end
        RBUS: begin
          if (wb_ack_i)     tx_data <= wb_dat_i;
          else if (tmo_hit) tx_data <= 8'hFF;
        end
        RSEND: begin
          if (tx_fire) begin
            addr <= addr + 24'd1;
            cnt  <= cnt - 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_byte_bridge.sv
// Directed bench for wb_byte_bridge: table of write bursts plus hand-written
// read, timeout, reset and throughput sequences against a simple wishbone slave.
module tb_wb_byte_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:7]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [0:7]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [0:23] wb_adr_o;
  logic [0:7]  wb_dat_o;
  logic [0:7]  wb_dat_i;
  logic        wb_we_o;
  logic [0:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;
  logic        timeout;

  wb_byte_bridge #(.timeout_cycles(4)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Slave: mode 0 = immediate ack, 1 = never ack, 2 = ack on stb cycle ack_lat.
  int ack_mode = 0;
  int ack_lat  = 1;
  int stb_run  = 0;

  function automatic logic [7:0] slave_data(input logic [23:0] a);
    if (a == 24'hFFFFFF)      return 8'h5A;
    else if (a == 24'h000000) return 8'hC3;
    else                      return a[7:0] ^ 8'hA5;
  endfunction

  assign wb_dat_i = slave_data(wb_adr_o);
  assign wb_ack_i = wb_stb_o && ((ack_mode == 0) || (ack_mode == 2 && stb_run == ack_lat - 1));

  always @(posedge clk) stb_run <= wb_stb_o ? stb_run + 1 : 0;

  typedef struct packed { logic [23:0] adr; logic [7:0] dat; } wr_t;

  int          cycle = 0;
  wr_t         wr_q[$];
  logic [23:0] rd_q[$];
  logic [7:0]  tx_q[$];
  int          rx_cyc_q[$];
  int          stb_n = 0;
  int          tmo_n = 0;
  int          stab_n = 0;
  int          stab_bad = 0;
  logic        tx_wait = 1'b0;
  logic [7:0]  tx_last = 8'h00;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) rx_cyc_q.push_back(cycle);
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
      if (wb_we_o) wr_q.push_back(wr_t'({wb_adr_o, wb_dat_o}));
      else         rd_q.push_back(wb_adr_o);
    end
    if (wb_stb_o) stb_n <= stb_n + 1;
    if (timeout)  tmo_n <= tmo_n + 1;
    if (tx_wait && tx_valid) begin
      stab_n <= stab_n + 1;
      if (tx_data !== tx_last) stab_bad <= stab_bad + 1;
    end
    tx_wait <= tx_valid && !tx_ready;
    tx_last <= tx_data;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the byte is taken.
  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rx_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    if (!ok) check("rx_accept_bound", 32'd0, 32'd1);
  endtask

  task automatic set_addr(input logic [23:0] a);
    send_byte(8'h01);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  typedef struct {
    logic [23:0] base;
    logic [7:0]  d0, d1;
    logic [23:0] a0, a1, fin;
  } wvec_t;

  wvec_t wtab[3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0, t0, q0, r0, b0;
    logic [7:0] d;

    wtab[0] = '{24'h123456, 8'hAA, 8'hBB, 24'h123456, 24'h123457, 24'h123458};
    wtab[1] = '{24'hFFFFFF, 8'h11, 8'h22, 24'hFFFFFF, 24'h000000, 24'h000001};
    wtab[2] = '{24'h00FFFF, 8'h5C, 8'hE7, 24'h00FFFF, 24'h010000, 24'h010001};

    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    idle(3);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_we", wb_we_o, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_adr", wb_adr_o, 0);
    check("rst_dat_o", wb_dat_o, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_sel", wb_sel_o, 1);
    reset = 1'b0;
    idle(1);
    check("idle_rx_ready", rx_ready, 1);

    // Write bursts of two bytes from the table.
    for (int i = 0; i < 3; i++) begin
      wr_q.delete();
      set_addr(wtab[i].base);
      send_byte(8'h02); send_byte(8'h02);
      send_byte(wtab[i].d0); send_byte(wtab[i].d1);
      idle(6);
      check($sformatf("wr%0d_count", i), wr_q.size(), 2);
      if (wr_q.size() == 2) begin
        check($sformatf("wr%0d_adr0", i), wr_q[0].adr, wtab[i].a0);
        check($sformatf("wr%0d_dat0", i), wr_q[0].dat, wtab[i].d0);
        check($sformatf("wr%0d_adr1", i), wr_q[1].adr, wtab[i].a1);
        check($sformatf("wr%0d_dat1", i), wr_q[1].dat, wtab[i].d1);
      end
      check($sformatf("wr%0d_fin_adr", i), wb_adr_o, wtab[i].fin);
      check($sformatf("wr%0d_cyc_idle", i), wb_cyc_o, 0);
    end

    // Two-byte read across the address wrap.
    rd_q.delete(); q0 = tx_q.size();
    set_addr(24'hFFFFFF);
    send_byte(8'h03); send_byte(8'h02);
    idle(12);
    check("rd_tx_count", tx_q.size() - q0, 2);
    if (tx_q.size() - q0 == 2) begin
      check("rd_tx0", tx_q[q0], 8'h5A);
      check("rd_tx1", tx_q[q0+1], 8'hC3);
    end
    check("rd_bus_count", rd_q.size(), 2);
    if (rd_q.size() == 2) begin
      check("rd_adr0", rd_q[0], 24'hFFFFFF);
      check("rd_adr1", rd_q[1], 24'h000000);
    end
    check("rd_fin_adr", wb_adr_o, 24'h000001);

    // Read with no ack: aborted after 4 strobe cycles, 0xFF returned.
    ack_mode = 1;
    set_addr(24'h000040);
    s0 = stb_n; t0 = tmo_n; q0 = tx_q.size();
    send_byte(8'h03); send_byte(8'h01);
    idle(12);
    check("tmo_stb_cycles", stb_n - s0, 4);
    check("tmo_pulses", tmo_n - t0, 1);
    check("tmo_tx_count", tx_q.size() - q0, 1);
    if (tx_q.size() - q0 == 1) check("tmo_tx_byte", tx_q[q0], 8'hFF);
    check("tmo_adr", wb_adr_o, 24'h000041);

    // Ack on the last allowed cycle is a normal completion.
    ack_mode = 2; ack_lat = 4;
    set_addr(24'h000080);
    s0 = stb_n; t0 = tmo_n; q0 = tx_q.size();
    send_byte(8'h03); send_byte(8'h01);
    idle(12);
    check("lateack_stb_cycles", stb_n - s0, 4);
    check("lateack_no_pulse", tmo_n - t0, 0);
    check("lateack_tx_count", tx_q.size() - q0, 1);
    if (tx_q.size() - q0 == 1) check("lateack_tx_byte", tx_q[q0], 8'h25);
    check("lateack_adr", wb_adr_o, 24'h000081);

    // Reset while a strobe waits for ack.
    ack_mode = 1;
    set_addr(24'hABCDEF);
    send_byte(8'h03); send_byte(8'h01);
    b0 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wb_stb_o) begin b0 = 1; break; end
    end
    check("midrst_stb_seen", b0, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    t0 = tmo_n;
    idle(1);
    check("midrst_cyc", wb_cyc_o, 0);
    check("midrst_stb", wb_stb_o, 0);
    check("midrst_adr", wb_adr_o, 0);
    check("midrst_rx_ready", rx_ready, 0);
    reset = 1'b0;
    idle(8);
    check("midrst_no_timeout", tmo_n - t0, 0);
    check("midrst_idle_ready", rx_ready, 1);

    // Unknown opcode is dropped and the next command still parses.
    ack_mode = 0;
    send_byte(8'h7E);
    set_addr(24'h000010);
    idle(2);
    check("badop_adr", wb_adr_o, 24'h000010);

    // Back-to-back write data: one byte accepted every 3 cycles.
    wr_q.delete();
    set_addr(24'h000000);
    send_byte(8'h02); send_byte(8'h04);
    r0 = rx_cyc_q.size();
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
    idle(6);
    for (int i = 1; i < 4; i++)
      check($sformatf("thru_gap%0d", i), rx_cyc_q[r0+i] - rx_cyc_q[r0+i-1], 3);
    check("thru_wr_count", wr_q.size(), 4);
    if (wr_q.size() == 4) check("thru_last_wr", wr_q[3], {24'h000003, 8'h40});

    // 256-byte read with tx_ready held off 10 cycles per byte.
    tx_ready = 1'b0;
    set_addr(24'h000100);
    s0 = stab_n;
    q0 = tx_q.size();
    send_byte(8'h03); send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      b0 = 0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (tx_valid) begin b0 = 1; break; end
      end
      if (!b0) begin
        check("burst_tx_valid_bound", i, 256);
        break;
      end
      repeat (10) @(posedge clk);
      #1 tx_ready = 1'b1;
      @(posedge clk);
      #1 tx_ready = 1'b0;
    end
    idle(20);
    check("burst_tx_count", tx_q.size() - q0, 256);
    if (tx_q.size() - q0 == 256) begin
      for (int i = 0; i < 256; i++) begin
        d = i[7:0] ^ 8'hA5;
        check($sformatf("burst_tx%0d", i), tx_q[q0+i], d);
      end
    end
    check("burst_fin_adr", wb_adr_o, 24'h000200);
    check("burst_stable_waits", (stab_n - s0) >= 2560, 1);
    check("burst_tx_stable", stab_bad, 0);
    check("burst_idle_ready", rx_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
